// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions: hazard FSM encoding, x0 index and control bundles.
package hazard_ctrl_pkg;

  // Hazard controller FSM states
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } hz_state_e;

  // Architectural zero register; never a real producer
  localparam logic [4:0] REG_X0 = 5'd0;

  // Pipeline enable/kill bundle driven by the hazard controller
  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_RUN    = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0, idex_bubble: 1'b0};
  localparam hz_ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, idex_bubble: 1'b0};
  localparam hz_ctrl_t CTRL_FLUSH  = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1, idex_bubble: 1'b1};
  localparam hz_ctrl_t CTRL_BUBBLE = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, idex_bubble: 1'b1};

endpackage

// File: rtl/hazard_cmp.sv
// Load-use comparator: flags when the load in EX produces a register the ID instruction reads.
module hazard_cmp
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs2,
  input  logic       ex_memread,
  input  logic [4:0] ex_rd,
  output logic       lu
);

  // x0 is never a dependency, even when the consumer names x0
  always_comb begin
    lu = 1'b0;
    if (ex_memread && (ex_rd != REG_X0)) begin
      lu = (ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2));
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: load-use stalls, taken-branch flushes, memory freeze, perf counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned STALL_CYCLES = 1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs2,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  input  logic             cnt_clr,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic             busy_stall
);

  localparam logic [3:0] REM_INIT = 4'(STALL_CYCLES - 1);

  hz_state_e        state_q, state_d;
  logic [3:0]       rem_q, rem_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             lu;
  logic             stall_inc;
  logic             flush_inc;
  hz_ctrl_t         ctrl;

  hazard_cmp u_cmp (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs2 (id_uses_rs2),
    .ex_memread  (ex_memread),
    .ex_rd       (ex_rd),
    .lu          (lu)
  );

  // Next state and Mealy controls; priority: freeze, flush, stall/load-use, run
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    ctrl      = CTRL_RUN;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (mem_busy) begin
      ctrl = CTRL_FREEZE;
    end else if (ex_branch_taken) begin
      ctrl      = CTRL_FLUSH;
      state_d   = ST_RUN;
      rem_d     = '0;
      flush_inc = 1'b1;
    end else if (state_q == ST_STALL) begin
      ctrl      = CTRL_BUBBLE;
      stall_inc = 1'b1;
      rem_d     = rem_q - 4'd1;
      if (rem_q == 4'd1) begin
        state_d = ST_RUN;
      end
    end else if (lu) begin
      ctrl      = CTRL_BUBBLE;
      stall_inc = 1'b1;
      if (STALL_CYCLES > 1) begin
        state_d = ST_STALL;
        rem_d   = REM_INIT;
      end
    end
    // Reset overrides the Mealy path so the pipeline free-runs while held
    if (!reset_n) begin
      ctrl = CTRL_RUN;
    end
  end

  // Saturating counters; clear wins over increment
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall_inc && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (flush_inc && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // State, remaining-cycle and counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_RUN;
      rem_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign pc_write    = ctrl.pc_write;
  assign ifid_write  = ctrl.ifid_write;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_bubble = ctrl.idex_bubble;
  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
  assign busy_stall  = (state_q == ST_STALL);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three configurations driven in lockstep against a bubble-budget model.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs2, ex_memread, ex_branch_taken, mem_busy, cnt_clr;

  logic [2:0]  pw, iw, fl, bb, bs;
  logic [31:0] sc_a, fc_a, sc_b, fc_b;
  logic [3:0]  sc_c, fc_c;

  hazard_ctrl #(.STALL_CYCLES(1), .CNT_W(32)) u_sc1 (
    .clk(clk), .reset_n(reset_n), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .cnt_clr(cnt_clr), .pc_write(pw[0]), .ifid_write(iw[0]), .ifid_flush(fl[0]), .idex_bubble(bb[0]),
    .stall_count(sc_a), .flush_count(fc_a), .busy_stall(bs[0]));

  hazard_ctrl #(.STALL_CYCLES(3), .CNT_W(32)) u_sc3 (
    .clk(clk), .reset_n(reset_n), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .cnt_clr(cnt_clr), .pc_write(pw[1]), .ifid_write(iw[1]), .ifid_flush(fl[1]), .idex_bubble(bb[1]),
    .stall_count(sc_b), .flush_count(fc_b), .busy_stall(bs[1]));

  hazard_ctrl #(.STALL_CYCLES(3), .CNT_W(4)) u_w4 (
    .clk(clk), .reset_n(reset_n), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .cnt_clr(cnt_clr), .pc_write(pw[2]), .ifid_write(iw[2]), .ifid_flush(fl[2]), .idex_bubble(bb[2]),
    .stall_count(sc_c), .flush_count(fc_c), .busy_stall(bs[2]));

  // Model: each instance owes a number of further bubble cycles after the current one
  int unsigned       cfg_sc [3] = '{1, 3, 3};
  longint unsigned   cfg_max[3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};
  int unsigned       owed   [3];
  longint unsigned   m_stall[3];
  longint unsigned   m_flush[3];

  int vectors;
  int miscompares;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_lu();
    if (!ex_memread || ex_rd == 5'd0) return 1'b0;
    return (ex_rd == id_rs1) || (id_uses_rs2 && ex_rd == id_rs2);
  endfunction

  function automatic logic [63:0] obs_stall(input int i);
    case (i)
      0:       return {32'd0, sc_a};
      1:       return {32'd0, sc_b};
      default: return {60'd0, sc_c};
    endcase
  endfunction

  function automatic logic [63:0] obs_flush(input int i);
    case (i)
      0:       return {32'd0, fc_a};
      1:       return {32'd0, fc_b};
      default: return {60'd0, fc_c};
    endcase
  endfunction

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u2,
                        input logic mr, input logic [4:0] rd, input logic br,
                        input logic busy, input logic clr);
    id_rs1 = rs1; id_rs2 = rs2; id_uses_rs2 = u2; ex_memread = mr; ex_rd = rd;
    ex_branch_taken = br; mem_busy = busy; cnt_clr = clr;
  endtask

  task automatic idle();
    set_in(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // One clock: check every instance against the model, advance the model, cross the edge
  task automatic cycle(input string tag);
    logic [3:0] exp_ctrl;
    bit         lu;
    bit         stall_now, flush_now;
    #1;
    lu = model_lu();
    for (int i = 0; i < 3; i++) begin
      stall_now = 1'b0;
      flush_now = 1'b0;
      if (!reset_n) begin
        owed[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
        exp_ctrl = 4'b1100;
      end else if (mem_busy) begin
        exp_ctrl = 4'b0000;
      end else if (ex_branch_taken) begin
        exp_ctrl = 4'b1111; flush_now = 1'b1;
      end else if (owed[i] > 0 || lu) begin
        exp_ctrl = 4'b0001; stall_now = 1'b1;
      end else begin
        exp_ctrl = 4'b1100;
      end
      chk($sformatf("%s.u%0d.ctrl", tag, i), {60'd0, pw[i], iw[i], fl[i], bb[i]}, {60'd0, exp_ctrl});
      chk($sformatf("%s.u%0d.busy", tag, i), {63'd0, bs[i]}, {63'd0, owed[i] > 0});
      chk($sformatf("%s.u%0d.stall_count", tag, i), obs_stall(i), m_stall[i]);
      chk($sformatf("%s.u%0d.flush_count", tag, i), obs_flush(i), m_flush[i]);
      if (reset_n) begin
        if (flush_now) owed[i] = 0;
        else if (stall_now) owed[i] = (owed[i] > 0) ? owed[i] - 1 : cfg_sc[i] - 1;
        if (cnt_clr) begin
          m_stall[i] = 0; m_flush[i] = 0;
        end else begin
          if (stall_now && m_stall[i] < cfg_max[i]) m_stall[i]++;
          if (flush_now && m_flush[i] < cfg_max[i]) m_flush[i]++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    for (int i = 0; i < 3; i++) begin owed[i] = 0; m_stall[i] = 0; m_flush[i] = 0; end

    // Reset held with hazards and branches on the inputs
    reset_n = 1'b0;
    set_in(5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    cycle("rst_lu");
    set_in(5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
    cycle("rst_br");
    reset_n = 1'b1;
    idle();
    cycle("post_rst");

    // Single load-use hit on rs1
    set_in(5'd5, 5'd9, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    cycle("lu_rs1");
    idle();
    repeat (3) cycle("lu_rs1_tail");
    chk("sc1_single_stall", {32'd0, sc_a}, 64'd1);

    // Held load-use for three cycles after a counter clear
    set_in(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    cycle("clr");
    set_in(5'd3, 5'd8, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
    repeat (3) cycle("lu_held");
    idle();
    cycle("lu_held_done");
    chk("sc3_three_bubbles", {32'd0, sc_b}, 64'd3);

    // Non-hazards: rs2 unused, and x0 as producer
    set_in(5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    cycle("rs2_unused");
    set_in(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    cycle("x0_rd");
    set_in(5'd4, 5'd6, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0);
    cycle("lu_rs2");
    idle();
    repeat (3) cycle("lu_rs2_tail");

    // Branch beats a simultaneous load-use
    set_in(5'd5, 5'd0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    cycle("br_vs_lu");
    idle();
    cycle("br_after");

    // Branch aborting a stall in progress
    set_in(5'd5, 5'd0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    cycle("abort_lu");
    idle();
    cycle("abort_stall");
    set_in(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    cycle("abort_br");
    idle();
    cycle("abort_run");

    // Memory freeze in the middle of a stall
    set_in(5'd5, 5'd0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    cycle("frz_lu");
    set_in(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    repeat (4) cycle("frz_busy");
    idle();
    repeat (3) cycle("frz_resume");

    // Saturation with narrow counters, then clear racing a stall
    set_in(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    cycle("sat_clr");
    set_in(5'd5, 5'd0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    repeat (18) cycle("sat_stall");
    chk("w4_stall_saturated", {60'd0, sc_c}, 64'd15);
    set_in(5'd5, 5'd0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);
    cycle("sat_clr_lu");
    chk("w4_clear_wins", {60'd0, sc_c}, 64'd0);
    set_in(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    repeat (18) cycle("sat_flush");
    chk("w4_flush_saturated", {60'd0, fc_c}, 64'd15);
    idle();
    cycle("sat_done");

    // Reset asserted mid-stall
    set_in(5'd5, 5'd0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    cycle("mid_lu");
    reset_n = 1'b0;
    cycle("mid_rst");
    reset_n = 1'b1;
    idle();
    cycle("mid_release");

    // Random traffic with a small register pool so hazards are frequent
    for (int n = 0; n < 400; n++) begin
      reset_n = ($urandom_range(0, 149) != 0);
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0), ($urandom_range(0, 24) == 0));
      cycle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter STALL_CYCLES, default 1 (range 1..15): total load-use stall cycles, including the detection cycle.
REQ-002 SHALL have parameter CNT_W, default 32: width of the performance counters.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on posedge clk.
REQ-004 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port id_rs1, input, 5 bits: rs1 field of the instruction in ID.
REQ-006 SHALL have port id_rs2, input, 5 bits: rs2 field of the instruction in ID.
REQ-007 SHALL have port id_uses_rs2, input, 1 bit: ID instruction reads rs2 (R/S/B formats).
REQ-008 SHALL have port ex_memread, input, 1 bit: memreadout from the ID/EX register.
REQ-009 SHALL have port ex_rd, input, 5 bits: RDout from the ID/EX register.
REQ-010 SHALL have port ex_branch_taken, input, 1 bit: branchout AND ALU zero, resolved in EX.
REQ-011 SHALL have port mem_busy, input, 1 bit: data memory not ready; freeze the whole pipeline.
REQ-012 SHALL have port cnt_clr, input, 1 bit: synchronous clear of both counters.
REQ-013 SHALL have port pc_write, output, 1 bit: PC register write enable.
REQ-014 SHALL have port ifid_write, output, 1 bit: IF/ID register write enable.
REQ-015 SHALL have port ifid_flush, output, 1 bit: zero the IF/ID instruction on next capture.
REQ-016 SHALL have port idex_bubble, output, 1 bit: force all ID/EX control fields to 0 on next capture.
REQ-017 SHALL have port stall_count, output, CNT_W bits: number of load-use bubble cycles inserted.
REQ-018 SHALL have port flush_count, output, CNT_W bits: number of taken-branch flushes.
REQ-019 SHALL have port busy_stall, output, 1 bit: FSM is in STALL.

Function
REQ-020 SHALL flag a hazard (lu) when ex_memread=1, ex_rd!=0, and either ex_rd==id_rs1 or (id_uses_rs2=1 and ex_rd==id_rs2).
REQ-021 SHALL implement a two-state FSM, RUN and STALL, plus a 4-bit remaining-cycle counter rem.
REQ-022 SHALL compute the outputs combinationally from state and the current inputs (Mealy), giving zero-cycle response.
REQ-023 SHALL apply this priority, highest first: mem_busy, then ex_branch_taken, then STALL/lu, then normal.
REQ-024 SHALL, when mem_busy=1: drive pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=0; hold state, rem and counters.
REQ-025 SHALL, when ex_branch_taken=1: drive pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1; go to RUN; increment flush_count. This aborts any stall in progress.
REQ-026 SHALL, in RUN with lu=1: drive pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=1; increment stall_count.
REQ-027 SHALL, in that case, go to STALL with rem=STALL_CYCLES-1 if STALL_CYCLES>1, and otherwise stay in RUN.
REQ-028 SHALL, in STALL: drive the same outputs as REQ-026 and increment stall_count each cycle.
REQ-029 SHALL, in STALL: set rem to rem-1 each cycle, and go to RUN in the cycle where rem==1.
REQ-030 SHALL, in RUN with no event: drive pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0.
REQ-031 SHALL make both counters saturate at all-ones and never wrap.
REQ-032 SHALL give cnt_clr priority over any increment in the same cycle; state is unaffected by cnt_clr.
REQ-033 SHALL never flag a hazard for ex_rd=0, even when id_rs1=0.

Reset
REQ-034 SHALL, while reset_n=0, immediately force state=RUN, rem=0, stall_count=0, flush_count=0, busy_stall=0.
REQ-035 SHALL, while reset_n=0, force the outputs pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, regardless of the other inputs.
REQ-036 SHALL, on reset assertion in the middle of a STALL, abandon the stall; the first cycle after release behaves as RUN.

Structure
REQ-037 SHALL place the state encoding (RUN=0, STALL=1) and the x0 register index constant in the shared pipeline package.
REQ-038 SHALL put the hazard comparator in a sub-module, hazard_cmp (pure combinational, outputs lu), reusable by the forwarding unit.

Verification
REQ-039 SHALL cover: STALL_CYCLES=1, ex_memread=1, ex_rd=5, id_rs1=5 -> a single cycle with pc_write=0, idex_bubble=1, and stall_count 0->1.
REQ-040 SHALL cover: STALL_CYCLES=3, lu held -> exactly 3 bubble cycles, busy_stall high for cycles 2-3, stall_count=3.
REQ-041 SHALL cover: id_uses_rs2=0, ex_rd=7, id_rs2=7 -> no stall; ex_rd=0, id_rs1=0, ex_memread=1 -> no stall.
REQ-042 SHALL cover: ex_branch_taken=1 and lu=1 in the same cycle -> ifid_flush=1, pc_write=1, flush_count +1, stall_count unchanged.
REQ-043 SHALL cover: mem_busy=1 for 4 cycles during STALL (rem=2) -> all enables 0, rem held at 2, then the stall completes normally.
REQ-044 SHALL cover: counters preloaded near all-ones (CNT_W=4), continued stalls -> stall_count holds at 15; cnt_clr plus a stall in the same cycle -> 0.
